// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// Ports: clk, rst_n, req/data/gnt (producers), fifo_* (FIFO side), err_overflow; ARB_STATS_EN adds wr_count/stall_count.
module fifo_wr_arbiter #(
  parameter int FIFO_WIDTH = 16,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          fifo_wr_en,
  output logic [FIFO_WIDTH-1:0]         fifo_data_in,
  input  logic                          fifo_full,
  input  logic                          fifo_almostfull,
  input  logic                          fifo_overflow,
  output logic                          err_overflow
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]                   wr_count,
  output logic [15:0]                   stall_count
`endif
);

  localparam int IW = $clog2(NUM_REQ);

  localparam logic IDLE = 1'b0;
  localparam logic BUSY = 1'b1;

  logic                  state;
  logic [IW-1:0]         owner;
  logic [IW-1:0]         rr_ptr;
  logic [IW-1:0]         pick;
  logic [IW-1:0]         rr_next;
  logic [3:0]            burst_cnt;
  logic                  found;
  logic                  stall;
  logic                  xfer;
  logic                  last;
  logic                  rel;
  logic [FIFO_WIDTH-1:0] owner_data;

  // Almostfull only matters when a write is already registered:
  // that write takes the last free slot.
  assign stall = fifo_full | (fifo_almostfull & fifo_wr_en);

  always_comb begin
    int j;
    logic [IW-1:0] idx;
    j     = 0;
    idx   = '0;
    found = 1'b0;
    pick  = rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      idx = IW'(j);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    owner_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner == IW'(i))
        owner_data = data[i*FIFO_WIDTH +: FIFO_WIDTH];
    end
  end

  always_comb begin
    gnt = '0;
    if (state == BUSY && !stall)
      gnt[owner] = 1'b1;
  end

  assign xfer    = (state == BUSY) & req[owner] & ~stall;
  assign last    = (burst_cnt == 4'(MAX_BURST - 1));
  assign rel     = (state == BUSY) & ((xfer & last) | ~req[owner]);
  assign rr_next = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      owner        <= '0;
      rr_ptr       <= '0;
      burst_cnt    <= '0;
      fifo_wr_en   <= 1'b0;
      fifo_data_in <= '0;
    end else begin
      case (state)
        IDLE: begin
          fifo_wr_en <= 1'b0;
          if (found) begin
            owner     <= pick;
            burst_cnt <= '0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          fifo_wr_en <= xfer;
          if (xfer) begin
            fifo_data_in <= owner_data;
            burst_cnt    <= burst_cnt + 4'd1;
          end
          if (rel) begin
            rr_ptr <= rr_next;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_overflow <= 1'b0;
    else if (fifo_overflow)
      err_overflow <= 1'b1;
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_count    <= '0;
      stall_count <= '0;
    end else begin
      if (fifo_wr_en && wr_count != 16'hFFFF)
        wr_count <= wr_count + 16'd1;
      if (state == BUSY && req[owner] && stall &&
          stall_count != 16'hFFFF)
        stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized bench for fifo_wr_arbiter against a transaction-level model.
// Includes a small FIFO occupancy model to drive full/almostfull.
module tb_fifo_wr_arbiter;

  localparam int W     = 16;
  localparam int N     = 4;
  localparam int MB    = 2;
  localparam int DEPTH = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] data;
  logic [N-1:0]   gnt;
  logic           fifo_wr_en;
  logic [W-1:0]   fifo_data_in;
  logic           fifo_full;
  logic           fifo_almostfull;
  logic           fifo_overflow;
  logic           err_overflow;
`ifdef ARB_STATS_EN
  logic [15:0]    wr_count;
  logic [15:0]    stall_count;
`endif

  fifo_wr_arbiter #(
    .FIFO_WIDTH(W), .NUM_REQ(N), .MAX_BURST(MB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .data(data), .gnt(gnt),
    .fifo_wr_en(fifo_wr_en), .fifo_data_in(fifo_data_in),
    .fifo_full(fifo_full), .fifo_almostfull(fifo_almostfull),
    .fifo_overflow(fifo_overflow), .err_overflow(err_overflow)
`ifdef ARB_STATS_EN
    , .wr_count(wr_count), .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // producers: current word per source, held until accepted
  logic [W-1:0] word [N];
  int           acc  [N];

  // model: owner index or -1 when nobody owns the port
  int           own;
  int           rr;
  int           taken;
  bit           m_wr;
  logic [W-1:0] m_din;
  bit           m_err;
  int           m_wrc;
  int           m_stc;
  int           fcnt;
  int           ovf_cnt = 0;

  task automatic model_reset();
    own   = -1;
    rr    = 0;
    taken = 0;
    m_wr  = 0;
    m_din = '0;
    m_err = 0;
    m_wrc = 0;
    m_stc = 0;
    fcnt  = 0;
  endtask

  task automatic step(input int req_pct, input logic [N-1:0] mask,
                      input int rd_pct, input bit ovf);
    bit           stall;
    bit           rd;
    bit           xfer;
    logic [N-1:0] eg;
    @(negedge clk);
    chk("wr_en", 32'(fifo_wr_en), 32'(m_wr));
    chk("data_in", 32'(fifo_data_in), 32'(m_din));
    chk("err_overflow", 32'(err_overflow), 32'(m_err));
`ifdef ARB_STATS_EN
    chk("wr_count", 32'(wr_count), 32'(m_wrc));
    chk("stall_count", 32'(stall_count), 32'(m_stc));
`endif
    for (int i = 0; i < N; i++) begin
      req[i] = mask[i] && ($urandom_range(99) < req_pct);
      data[i*W +: W] = word[i];
    end
    fifo_full       = (fcnt == DEPTH);
    fifo_almostfull = (fcnt == DEPTH - 1);
    fifo_overflow   = ovf;
    #1;
    stall = fifo_full || (fifo_almostfull && m_wr);
    eg = '0;
    if (own >= 0 && !stall) eg[own] = 1'b1;
    chk("gnt", 32'(gnt), 32'(eg));

    rd = (fcnt > 0) && ($urandom_range(99) < rd_pct);
    if (m_wr && fcnt == DEPTH) ovf_cnt++;
    if (m_wr && m_wrc != 16'hFFFF) m_wrc++;
    if (own >= 0 && req[own] && stall && m_stc != 16'hFFFF) m_stc++;
    fcnt = fcnt + int'(m_wr) - int'(rd);
    if (fcnt > DEPTH) fcnt = DEPTH;
    if (ovf) m_err = 1;

    if (own < 0) begin
      m_wr = 0;
      for (int k = 0; k < N; k++) begin
        if (own < 0 && req[(rr + k) % N]) begin
          own   = (rr + k) % N;
          taken = 0;
        end
      end
    end else begin
      xfer = req[own] && !stall;
      m_wr = xfer;
      if (xfer) begin
        m_din = word[own];
        taken++;
      end
      if ((xfer && taken == MB) || !req[own]) begin
        rr  = (own + 1) % N;
        own = -1;
      end
    end

    for (int i = 0; i < N; i++) begin
      if (req[i] && eg[i]) begin
        word[i] = W'($urandom);
        acc[i]++;
      end
    end
  endtask

  initial begin
    rst_n           = 1'b0;
    req             = '0;
    data            = '0;
    fifo_full       = 1'b0;
    fifo_almostfull = 1'b0;
    fifo_overflow   = 1'b0;
    for (int i = 0; i < N; i++) begin
      word[i] = W'($urandom);
      acc[i]  = 0;
    end
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("rst_data_in", 32'(fifo_data_in), 32'd0);
    chk("rst_err", 32'(err_overflow), 32'd0);
    chk("rst_gnt", 32'(gnt), 32'd0);
    rst_n = 1'b1;

    // single producer, FIFO always drained: A,B, bubble, C
    repeat (12) step(100, 4'b0100, 100, 0);
    // all producers held: rotation 0,1,2,3,0
    repeat (30) step(100, 4'b1111, 100, 0);
    // no reads: FIFO fills and stalls, then drains
    repeat (20) step(100, 4'b1111, 0, 0);
    repeat (20) step(100, 4'b1111, 100, 0);

    // reset in the middle of a burst
    for (int c = 0; c < 50 && !m_wr; c++) step(100, 4'b1111, 100, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("midrst_gnt", 32'(gnt), 32'd0);
    req = '0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) step(100, 4'b1111, 100, 0);

    // sticky overflow error
    step(70, 4'b1111, 60, 1);
    repeat (10) step(70, 4'b1111, 60, 0);

    // random traffic with varying drain rate
    for (int p = 0; p < 8; p++) begin
      int rp;
      rp = $urandom_range(20, 100);
      repeat (250) step(70, 4'b1111, rp, 0);
    end

    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    #1;
    chk("err_cleared", 32'(err_overflow), 32'd0);
    chk("no_overflow", 32'(ovf_cnt), 32'd0);
    for (int i = 0; i < N; i++)
      chk($sformatf("served_%0d", i), 32'(acc[i] > 0), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
